camera_stream_tx: RTL and testbench
===================================

Name: camera_stream_tx

Overview:
- Camera-side transmitter: generates an OV7670-style parallel pixel stream (VSYNC, HREF, 8-bit DATA, two bytes per pixel) from an RGB332 pixel source.
- Byte order and framing match what our camera capture receiver decodes, so the block can stand in for the sensor in simulation and on-board loopback tests.
- Pixel source is typically a frame-buffer reader addressed by PIX_X/PIX_Y.

Parameters:
- H_ACTIVE, 176, pixels per line (line lasts 2*H_ACTIVE byte cycles)
- V_ACTIVE, 144, active lines per frame
- HBLANK_CYC, 16, cycles with HREF low after every active line
- VSYNC_CYC, 32, cycles VSYNC is high
- VBP_CYC, 64, cycles between VSYNC fall and first HREF rise
- VFP_CYC, 64, cycles after last line's HBLANK before next VSYNC / idle
- FILL, 8'h00, RGB332 value sent on underrun

Ports:
- PCLK  in  1  byte clock; all logic on rising edge
- RESET_N  in  1  asynchronous, active-low reset
- ENABLE  in  1  level; frames start only while high
- PIXEL_IN  in  8  RGB332 pixel {R[2:0],G[2:0],B[1:0]}
- PIXEL_VALID  in  1  source holds a pixel
- PIXEL_READY  out  1  transmitter takes a pixel at this edge if PIXEL_VALID
- PIX_X  out  10  column of pixel requested while PIXEL_READY=1
- PIX_Y  out  10  line of pixel requested while PIXEL_READY=1
- VSYNC  out  1  frame sync, active high
- HREF  out  1  line valid, active high
- DATA  out  8  stream byte
- FRAME_START  out  1  one-cycle pulse when VSYNC rises
- UNDERRUN_CNT  out  8  saturating count of filled pixels; clears at FRAME_START

Behaviour:
- All outputs are registered except PIXEL_READY, PIX_X and PIX_Y, which are decoded from state and counters.
- Reset (async, RESET_N=0): FSM to IDLE. VSYNC, HREF, FRAME_START, PIXEL_READY = 0. DATA, PIX_X, PIX_Y, UNDERRUN_CNT = 0.
- Reset mid-frame aborts immediately. No partial line completion.
- FSM states:
  - IDLE → VSYNC when ENABLE=1 is sampled.
  - VSYNC: VSYNC=1 for exactly VSYNC_CYC cycles → VBACK. FRAME_START is high on the first of these cycles.
  - VBACK: VBP_CYC cycles, all low → ACTIVE.
  - ACTIVE: HREF=1 for exactly 2*H_ACTIVE cycles → HBLANK.
  - HBLANK: HREF=0 for HBLANK_CYC cycles.
    - If the line counter is less than V_ACTIVE → ACTIVE (next line).
    - Otherwise → VFRONT. HBLANK always follows the last line, so the receiver sees HREF fall V_ACTIVE times per frame.
  - VFRONT: VFP_CYC cycles → VSYNC if ENABLE=1, else IDLE.
- ENABLE is checked only in IDLE and at the end of VFRONT. Dropping ENABLE mid-frame finishes the current frame.
- Byte phase inside ACTIVE alternates starting with byte0:
  - byte0 = {B,B,B,B} (blue replicated)
  - byte1 = {R,G,2'b00}
- DATA = 0 whenever HREF=0.
- PIXEL_READY = 1 for exactly one cycle per pixel: the cycle before that pixel's byte0 appears on DATA. This covers the last VBACK/HBLANK cycle and each byte1 cycle except the line's last pixel.
- PIX_X (0..H_ACTIVE-1) and PIX_Y (0..V_ACTIVE-1) name the requested pixel. Both are 0 otherwise.
- At a READY edge:
  - PIXEL_VALID=1: PIXEL_IN is latched.
  - PIXEL_VALID=0: FILL is latched and UNDERRUN_CNT increments, saturating at 255.
- The latched pixel drives byte0 (next cycle) and byte1 (cycle after). The stream never stalls.
- FRAME_START and an underrun in the same cycle cannot coincide, because READY is never high in VSYNC.
- Frame length in cycles = VSYNC_CYC + VBP_CYC + V_ACTIVE*(2*H_ACTIVE+HBLANK_CYC) + VFP_CYC.
- Counters wrap only via state transitions. Line and pixel counters reset at each VSYNC entry.

Test Plan:
1. Reset/idle: RESET_N=0 then 1 with ENABLE=0 for 100 cycles → VSYNC=HREF=DATA=PIXEL_READY=0 throughout.
2. Framing, with H_ACTIVE=4, V_ACTIVE=2, HBLANK_CYC=3, VSYNC_CYC=2, VBP_CYC=2, VFP_CYC=2, ENABLE=1:
   - VSYNC high 2 cycles; FRAME_START 1 pulse; HREF high runs of exactly 8 with gaps of 3; 2 HREF falls per frame.
   - Next VSYNC rises 2+2+2*11+2=28 cycles after the previous one.
3. Byte encoding, PIXEL_VALID=1:
   - PIXEL_IN=8'hAB ({101,010,11}) → DATA 8'hFF then 8'hA8.
   - PIXEL_IN=8'hE0 → 8'h00 then 8'hE0.
   - PIX_X/PIX_Y sequence at READY edges is (0,0),(1,0),(2,0),(3,0),(0,1),…,(3,1).
4. Underrun: PIXEL_VALID=0 for pixels (1,0) and (2,1), FILL=8'h03 → those pixels emit 8'hFF,8'h00; UNDERRUN_CNT=2 at frame end; 0 after next FRAME_START.
5. ENABLE drop: deassert ENABLE during line 0 → frame completes with 2 full lines, then IDLE, no further VSYNC. Reassert → VSYNC rises one cycle later.
6. Async reset mid-line: pull RESET_N low while HREF=1 → HREF, DATA, VSYNC go 0 without a clock edge. After release, the next frame starts with a fresh VSYNC and PIX_X/PIX_Y restart at (0,0).

Source files
------------

// File: rtl/camera_stream_tx.sv
// camera_stream_tx: OV7670-style VSYNC/HREF/DATA generator fed by an RGB332 pixel source.
// Each pixel goes out as two bytes (blue replicated, then R/G); underruns send FILL and are counted.
module camera_stream_tx #(
  parameter int         H_ACTIVE   = 176,
  parameter int         V_ACTIVE   = 144,
  parameter int         HBLANK_CYC = 16,
  parameter int         VSYNC_CYC  = 32,
  parameter int         VBP_CYC    = 64,
  parameter int         VFP_CYC    = 64,
  parameter logic [7:0] FILL       = 8'h00
) (
  input  logic       PCLK,
  input  logic       RESET_N,
  input  logic       ENABLE,
  input  logic [7:0] PIXEL_IN,
  input  logic       PIXEL_VALID,
  output logic       PIXEL_READY,
  output logic [9:0] PIX_X,
  output logic [9:0] PIX_Y,
  output logic       VSYNC,
  output logic       HREF,
  output logic [7:0] DATA,
  output logic       FRAME_START,
  output logic [7:0] UNDERRUN_CNT
);

  localparam logic [15:0] VSYNC_LAST = 16'(VSYNC_CYC - 1);
  localparam logic [15:0] VBP_LAST   = 16'(VBP_CYC - 1);
  localparam logic [15:0] LINE_LAST  = 16'(2 * H_ACTIVE - 1);
  localparam logic [15:0] HB_LAST    = 16'(HBLANK_CYC - 1);
  localparam logic [15:0] VFP_LAST   = 16'(VFP_CYC - 1);
  localparam logic [9:0]  V_LINES    = 10'(V_ACTIVE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_VSYNC,
    S_VBACK,
    S_ACTIVE,
    S_HBLANK,
    S_VFRONT
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] cnt;
  logic [9:0]  x_req;
  logic [9:0]  line_cnt;
  logic [5:0]  pix_hi;
  logic [7:0]  pix_sel;
  logic        phase_end;
  logic        frame_entry;
  logic        line_done;

  always_ff @(posedge PCLK or negedge RESET_N) begin
    if (!RESET_N) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // cnt counts cycles spent in the current state; in ACTIVE its LSB is the byte phase.
  always_comb begin
    state_nxt   = state;
    PIXEL_READY = 1'b0;
    phase_end   = 1'b0;
    case (state)
      S_IDLE: begin
        if (ENABLE) state_nxt = S_VSYNC;
      end
      S_VSYNC: begin
        phase_end = (cnt == VSYNC_LAST);
        if (phase_end) state_nxt = S_VBACK;
      end
      S_VBACK: begin
        phase_end = (cnt == VBP_LAST);
        if (phase_end) begin
          state_nxt   = S_ACTIVE;
          PIXEL_READY = 1'b1;
        end
      end
      S_ACTIVE: begin
        phase_end   = (cnt == LINE_LAST);
        PIXEL_READY = cnt[0] && !phase_end;
        if (phase_end) state_nxt = S_HBLANK;
      end
      S_HBLANK: begin
        phase_end = (cnt == HB_LAST);
        if (phase_end) begin
          if (line_cnt < V_LINES) begin
            state_nxt   = S_ACTIVE;
            PIXEL_READY = 1'b1;
          end else begin
            state_nxt = S_VFRONT;
          end
        end
      end
      S_VFRONT: begin
        phase_end = (cnt == VFP_LAST);
        if (phase_end) state_nxt = ENABLE ? S_VSYNC : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign frame_entry = (state_nxt == S_VSYNC) && (state != S_VSYNC);
  assign line_done   = (state == S_ACTIVE) && phase_end;
  assign PIX_X       = PIXEL_READY ? x_req : 10'd0;
  assign PIX_Y       = PIXEL_READY ? line_cnt : 10'd0;
  assign pix_sel     = PIXEL_VALID ? PIXEL_IN : FILL;

  // line_cnt holds the current line in ACTIVE and the number of finished lines in HBLANK.
  always_ff @(posedge PCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt      <= '0;
      x_req    <= '0;
      line_cnt <= '0;
    end else begin
      if ((state_nxt != state) || (state == S_IDLE)) cnt <= '0;
      else                                           cnt <= cnt + 16'd1;

      if (frame_entry || line_done) x_req <= '0;
      else if (PIXEL_READY)         x_req <= x_req + 10'd1;

      if (frame_entry)    line_cnt <= '0;
      else if (line_done) line_cnt <= line_cnt + 10'd1;
    end
  end

  // Outputs are registered from the next state so they line up with the cycle they describe.
  always_ff @(posedge PCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      VSYNC        <= 1'b0;
      HREF         <= 1'b0;
      FRAME_START  <= 1'b0;
      DATA         <= '0;
      pix_hi       <= '0;
      UNDERRUN_CNT <= '0;
    end else begin
      VSYNC       <= (state_nxt == S_VSYNC);
      HREF        <= (state_nxt == S_ACTIVE);
      FRAME_START <= frame_entry;

      if (PIXEL_READY) begin
        pix_hi <= pix_sel[7:2];
        DATA   <= {4{pix_sel[1:0]}};
      end else if (state_nxt == S_ACTIVE) begin
        DATA <= {pix_hi, 2'b00};
      end else begin
        DATA <= '0;
      end

      if (frame_entry)
        UNDERRUN_CNT <= '0;
      else if (PIXEL_READY && !PIXEL_VALID && (UNDERRUN_CNT != 8'hFF))
        UNDERRUN_CNT <= UNDERRUN_CNT + 8'd1;
    end
  end

endmodule

// File: tb/tb_camera_stream_tx.sv
// Randomized bench for camera_stream_tx: a frame-position model predicts every output,
// and expected stream bytes flow through a scoreboard queue popped whenever HREF is high.
module tb_camera_stream_tx;

  localparam int         H        = 4;
  localparam int         V        = 2;
  localparam int         HB       = 3;
  localparam int         VS       = 2;
  localparam int         VBP      = 2;
  localparam int         VFP      = 2;
  localparam logic [7:0] FILL_VAL = 8'h03;
  localparam int         LP       = 2 * H + HB;
  localparam int         BASE     = VS + VBP;
  localparam int         FL       = BASE + V * LP + VFP;

  logic       PCLK = 1'b0;
  logic       RESET_N;
  logic       ENABLE;
  logic [7:0] PIXEL_IN;
  logic       PIXEL_VALID;
  logic       PIXEL_READY;
  logic [9:0] PIX_X;
  logic [9:0] PIX_Y;
  logic       VSYNC;
  logic       HREF;
  logic [7:0] DATA;
  logic       FRAME_START;
  logic [7:0] UNDERRUN_CNT;

  int         checks    = 0;
  int         failures  = 0;
  logic [7:0] exp_q[$];
  bit         m_act     = 1'b0;
  int         m_k       = 0;
  int         m_und     = 0;
  int         drv_mode  = 0;
  logic [7:0] fixed_pix = 8'h00;

  camera_stream_tx #(
    .H_ACTIVE  (H),
    .V_ACTIVE  (V),
    .HBLANK_CYC(HB),
    .VSYNC_CYC (VS),
    .VBP_CYC   (VBP),
    .VFP_CYC   (VFP),
    .FILL      (FILL_VAL)
  ) dut (
    .PCLK        (PCLK),
    .RESET_N     (RESET_N),
    .ENABLE      (ENABLE),
    .PIXEL_IN    (PIXEL_IN),
    .PIXEL_VALID (PIXEL_VALID),
    .PIXEL_READY (PIXEL_READY),
    .PIX_X       (PIX_X),
    .PIX_Y       (PIX_Y),
    .VSYNC       (VSYNC),
    .HREF        (HREF),
    .DATA        (DATA),
    .FRAME_START (FRAME_START),
    .UNDERRUN_CNT(UNDERRUN_CNT)
  );

  always #5 PCLK = ~PCLK;

  // Frame geometry as plain arithmetic on the cycle index k within a frame.
  function automatic bit m_href_at(int k);
    int r;
    if (k < BASE || k >= FL) return 1'b0;
    r = k - BASE;
    return ((r / LP) < V) && ((r % LP) < 2 * H);
  endfunction

  function automatic bit m_ready_at(int k);
    return m_href_at(k + 1) && ((((k + 1 - BASE) % LP) % 2) == 0);
  endfunction

  function automatic int m_px(int k);
    return ((k + 1 - BASE) % LP) / 2;
  endfunction

  function automatic int m_py(int k);
    return (k + 1 - BASE) / LP;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input int mode, input int ncycles);
    drv_mode = mode;
    repeat (ncycles) @(negedge PCLK);
  endtask

  // what: 0 = VSYNC rise, 1 = HREF high, 2 = PIXEL_READY high
  task automatic waitFor(input int what, input int limit, input string name);
    logic prev;
    bit   hit;
    hit  = 1'b0;
    prev = VSYNC;
    for (int i = 0; i < limit && !hit; i++) begin
      @(negedge PCLK);
      case (what)
        0:       hit = (VSYNC === 1'b1) && (prev !== 1'b1);
        1:       hit = (HREF === 1'b1);
        default: hit = (PIXEL_READY === 1'b1);
      endcase
      prev = VSYNC;
    end
    if (!hit) begin
      checks++;
      failures++;
      $display("[TB] FAIL timeout_%s waited=%0d cycles required event not seen", name, limit);
    end
  endtask

  // Called on the first VSYNC cycle of a frame; walks to the next VSYNC rise.
  task automatic measureFrame(input logic [7:0] b0, input logic [7:0] b1);
    int         len, falls, nbytes;
    logic       ph, pv;
    logic [7:0] got0, got1;
    len = 0; falls = 0; nbytes = 0;
    ph = HREF; pv = VSYNC; got0 = 8'hxx; got1 = 8'hxx;
    for (int i = 0; i < 3 * FL; i++) begin
      @(negedge PCLK);
      len++;
      if (HREF === 1'b1) begin
        if (nbytes == 0)      got0 = DATA;
        else if (nbytes == 1) got1 = DATA;
        nbytes++;
      end
      if (ph === 1'b1 && HREF === 1'b0) falls++;
      if (VSYNC === 1'b1 && pv === 1'b0) break;
      ph = HREF;
      pv = VSYNC;
    end
    checkOutput("frame_period", len, FL);
    checkOutput("href_falls", falls, V);
    checkOutput("first_byte0", got0, b0);
    checkOutput("first_byte1", got1, b1);
  endtask

  // Reference model: advances one frame position per clock, pushes expected bytes at READY.
  initial begin
    logic [7:0] pv;
    forever begin
      @(posedge PCLK or negedge RESET_N);
      if (RESET_N !== 1'b1) begin
        m_act = 1'b0;
        m_k   = 0;
        m_und = 0;
        exp_q.delete();
      end else begin
        if (m_act && m_ready_at(m_k)) begin
          pv = PIXEL_VALID ? PIXEL_IN : FILL_VAL;
          exp_q.push_back({4{pv[1:0]}});
          exp_q.push_back({pv[7:2], 2'b00});
          if (!PIXEL_VALID && m_und != 255) m_und++;
        end
        if (!m_act) begin
          if (ENABLE) begin m_act = 1'b1; m_k = 0; m_und = 0; end
        end else if (m_k == FL - 1) begin
          if (ENABLE) begin m_k = 0; m_und = 0; end
          else m_act = 1'b0;
        end else begin
          m_k++;
        end
      end
    end
  end

  // Input driver: random, fixed-valid, or underrun on pixels (1,0) and (2,1).
  initial begin
    int px, py;
    PIXEL_IN = 8'h00;
    PIXEL_VALID = 1'b0;
    forever begin
      @(negedge PCLK);
      case (drv_mode)
        1: begin
          PIXEL_IN    = fixed_pix;
          PIXEL_VALID = 1'b1;
        end
        2: begin
          PIXEL_IN    = 8'($urandom);
          PIXEL_VALID = 1'b1;
          if (m_act && m_ready_at(m_k)) begin
            px = m_px(m_k);
            py = m_py(m_k);
            if ((px == 1 && py == 0) || (px == 2 && py == 1)) PIXEL_VALID = 1'b0;
          end
        end
        default: begin
          PIXEL_IN    = 8'($urandom);
          PIXEL_VALID = ($urandom_range(3) != 0);
        end
      endcase
    end
  end

  // Monitor: compares every output against the model each cycle, popping bytes while HREF is high.
  initial begin
    bit         e_rdy;
    logic [7:0] eb;
    forever begin
      @(negedge PCLK);
      e_rdy = m_act && m_ready_at(m_k);
      checkOutput("VSYNC", VSYNC, m_act && (m_k < VS));
      checkOutput("HREF", HREF, m_act && m_href_at(m_k));
      checkOutput("FRAME_START", FRAME_START, m_act && (m_k == 0));
      checkOutput("PIXEL_READY", PIXEL_READY, e_rdy);
      checkOutput("PIX_X", PIX_X, e_rdy ? m_px(m_k) : 0);
      checkOutput("PIX_Y", PIX_Y, e_rdy ? m_py(m_k) : 0);
      checkOutput("UNDERRUN_CNT", UNDERRUN_CNT, m_und);
      if (HREF === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL DATA_unexpected actual=%0h expected=none at %0t", DATA, $time);
        end else begin
          eb = exp_q.pop_front();
          checkOutput("DATA", DATA, eb);
        end
      end else begin
        checkOutput("DATA_blank", DATA, 0);
      end
    end
  end

  initial begin
    RESET_N = 1'b0;
    ENABLE  = 1'b0;
    repeat (3) @(negedge PCLK);
    RESET_N = 1'b1;
    applyStimulus(0, 100);

    // framing and byte encoding
    fixed_pix = 8'hAB;
    drv_mode  = 1;
    ENABLE    = 1'b1;
    waitFor(0, 10, "first_vsync");
    measureFrame(8'hFF, 8'hA8);
    fixed_pix = 8'hE0;
    measureFrame(8'h00, 8'hE0);

    // underrun on two chosen pixels of this frame
    drv_mode = 2;
    for (int i = 0; i < FL + 2; i++) begin
      @(negedge PCLK);
      if (m_act && m_k == FL - 1) break;
    end
    checkOutput("underrun_frame_end", UNDERRUN_CNT, 2);
    drv_mode = 0;
    @(negedge PCLK);
    checkOutput("frame_start_pulse", FRAME_START, 1);
    checkOutput("underrun_cleared", UNDERRUN_CNT, 0);

    applyStimulus(0, 3 * FL);

    // ENABLE dropped during line 0: frame completes, then idle
    waitFor(0, FL + 5, "vsync_before_drop");
    waitFor(1, 20, "href_line0");
    ENABLE = 1'b0;
    begin
      int   rises, falls;
      logic ph, pv;
      rises = 0; falls = 0; ph = HREF; pv = VSYNC;
      for (int i = 0; i < 2 * FL; i++) begin
        @(negedge PCLK);
        if (VSYNC === 1'b1 && pv === 1'b0) rises++;
        if (ph === 1'b1 && HREF === 1'b0) falls++;
        ph = HREF;
        pv = VSYNC;
      end
      checkOutput("vsync_after_drop", rises, 0);
      checkOutput("lines_after_drop", falls, V);
    end
    ENABLE = 1'b1;
    @(negedge PCLK);
    checkOutput("vsync_reenable", VSYNC, 1);

    // asynchronous reset while HREF is high
    waitFor(1, FL, "href_before_reset");
    @(posedge PCLK);
    #2 RESET_N = 1'b0;
    #1;
    checkOutput("rst_HREF", HREF, 0);
    checkOutput("rst_DATA", DATA, 0);
    checkOutput("rst_VSYNC", VSYNC, 0);
    checkOutput("rst_READY", PIXEL_READY, 0);
    repeat (3) @(negedge PCLK);
    RESET_N = 1'b1;
    waitFor(0, 10, "vsync_after_reset");
    waitFor(2, 10, "ready_after_reset");
    checkOutput("restart_PIX_X", PIX_X, 0);
    checkOutput("restart_PIX_Y", PIX_Y, 0);

    applyStimulus(0, 3 * FL);
    ENABLE = 1'b0;
    applyStimulus(0, FL + 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
